c1908_bist_ctrl: RTL and testbench
==================================

# c1908_bist_ctrl

Built-in self-test controller wrapped around the c1908 combinational benchmark. It sits on both sides of the CUT:
- Upstream, a 33-bit LFSR test-pattern generator drives all 33 CUT inputs.
- Downstream, a 25-bit MISR compacts all 25 CUT outputs into a signature that is compared against a golden value.

It lets the c1908 testability results from the SCOAP flow be checked against pseudo-random fault-detection runs on the same netlist.

## Interface
- Parameters: none. Widths are fixed: pattern 33, response 25, count 16.
- clk  input  1  single rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a test run; sampled only in IDLE
- seed  input  33  LFSR seed, sampled in LOAD
- num_pat  input  16  number of patterns to apply, sampled in LOAD
- golden  input  25  expected signature, sampled when entering DONE
- cut_in  output  33  pattern to CUT inputs 0..32; bit i drives CUT input i
- cut_out  input  25  CUT responses 0..24; bit j from CUT output j
- busy  output  1  high in LOAD and RUN
- done  output  1  one-cycle pulse in DONE
- pass  output  1  signature == golden; valid from DONE until the next LOAD
- signature  output  25  final MISR value; held until the next LOAD

## Operation
- States:
  - IDLE -> LOAD on start=1.
  - LOAD -> RUN if num_pat != 0, else LOAD -> DONE.
  - RUN -> DONE on the edge where cnt == num_pat-1.
  - DONE -> IDLE unconditionally.
- LOAD edge:
  - cut_in <= seed; if seed == 0, load 33'h1 instead (avoids LFSR lock-up).
  - misr <= 0, cnt <= 0.
  - num_pat is latched internally.
- LFSR (Fibonacci, x^33+x^20+1): next = {q[31:0], q[32]^q[19]}. Advances on every RUN edge.
- MISR (x^25+x^22+1): next = {m[23:0], m[24]^m[21]} ^ cut_out. Compacts on every RUN edge.
- Counter: cnt increments on each RUN edge and is 16 bits wide. The maximum is 65535 patterns, so there is no wrap within a run.
- Number of compacted responses = num_pat exactly. The first compacted response is the CUT response to the seed.
- Entering DONE: signature <= MISR next-value (or 0 if num_pat == 0), and pass <= (that value == golden).
- start while busy or in DONE is ignored; it is not queued.
- cut_in holds its last value in IDLE and DONE.
- Reset values: cut_in = 0, busy = 0, done = 0, pass = 0, signature = 0, state IDLE, misr = 0, cnt = 0.
- Reset mid-run: all state returns to reset values immediately; no done pulse is produced.

## Timing
- start sampled at edge E0 -> LOAD during cycle 1.
- RUN occupies cycles 2 .. num_pat+1.
- done is high during cycle num_pat+2 (0 patterns: cycle 2).
- busy is high from cycle 1 through cycle num_pat+1.
- The CUT is combinational. cut_out must settle within one clock of cut_in changing, and is sampled at the RUN edge that ends the pattern's cycle.
- Throughput: one pattern per clock, no bubbles.
- Back-to-back runs: start may be asserted in the IDLE cycle directly after DONE.

## Test plan
Bench stub for all scenarios: cut_out = cut_in[24:0] (loopback).
- seed=33'h1, num_pat=1, golden=25'h1 -> done 3 cycles after start; signature=25'h0000001, pass=1.
- seed=33'h1, num_pat=3, golden=25'h0 -> cut_in sequence 1, 2, 4; signature=25'h0000004, pass=0; busy high exactly 4 cycles.
- seed=0, num_pat=2 -> cut_in loads 33'h1 then 33'h2; signature=25'h0000000.
- num_pat=0, golden=0 -> LOAD then DONE; done 2 cycles after start; signature=0, pass=1.
- Run num_pat=100 and deassert rst_n at RUN cycle 50 -> all outputs 0 asynchronously, state IDLE, no done pulse. A following run with seed=1, num_pat=3 repeats the 25'h0000004 result.
- Pulse start again during RUN -> ignored; done pulses exactly once and signature matches the single-run value.

Source files
------------

// File: rtl/c1908_bist_ctrl.sv
// BIST wrapper for the c1908 benchmark: a 33-bit LFSR drives the CUT inputs and a
// 25-bit MISR compacts the CUT outputs into a signature checked against a golden value.
module c1908_bist_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [32:0] seed,
    input  logic [15:0] num_pat,
    input  logic [24:0] golden,
    output logic [32:0] cut_in,
    input  logic [24:0] cut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [24:0] signature
);

    // Handshake: start is a level sampled only in IDLE (ignored otherwise, never
    // queued); done is a one-cycle pulse and pass/signature stay valid after it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [24:0] misr;
    logic [15:0] cnt;
    logic [15:0] num_pat_q;
    logic [32:0] lfsr_nxt;
    logic [24:0] misr_nxt;
    logic        last_pat;

    always_comb begin
        lfsr_nxt = {cut_in[31:0], cut_in[32] ^ cut_in[19]};
        misr_nxt = {misr[23:0], misr[24] ^ misr[21]} ^ cut_out;
        last_pat = (cnt == (num_pat_q - 16'd1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                busy      = 1'b1;
                state_nxt = (num_pat != 16'd0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_pat) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: the LFSR state lives directly in cut_in so it holds outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cut_in    <= 33'd0;
            misr      <= 25'd0;
            cnt       <= 16'd0;
            num_pat_q <= 16'd0;
            signature <= 25'd0;
            pass      <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    cut_in    <= (seed == 33'd0) ? 33'd1 : seed;
                    misr      <= 25'd0;
                    cnt       <= 16'd0;
                    num_pat_q <= num_pat;
                    signature <= 25'd0;
                    pass      <= 1'b0;
                    if (num_pat == 16'd0) begin
                        pass <= (golden == 25'd0);
                    end
                end
                ST_RUN: begin
                    cut_in <= lfsr_nxt;
                    misr   <= misr_nxt;
                    cnt    <= cnt + 16'd1;
                    if (last_pat) begin
                        signature <= misr_nxt;
                        pass      <= (misr_nxt == golden);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_c1908_bist_ctrl.sv
// Bench for c1908_bist_ctrl: CUT modelled as loopback, per-cycle trace model plus
// hand-computed literal expectations for the directed scenarios.
module tb_c1908_bist_ctrl;

    typedef struct packed {
        logic [32:0] ci;
        logic        busy;
        logic        done;
        logic        pass;
        logic [24:0] sig;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [32:0] seed;
    logic [15:0] num_pat;
    logic [24:0] golden;
    logic [32:0] cut_in;
    logic [24:0] cut_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [24:0] signature;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    exp_t        exp_q[$];
    exp_t        hold = '0;
    logic [32:0] obs[0:15];

    c1908_bist_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .num_pat   (num_pat),
        .golden    (golden),
        .cut_in    (cut_in),
        .cut_out   (cut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    assign cut_out = cut_in[24:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Builds the whole expected output trace of one run from the seed, count and golden.
    function automatic void model_start(input logic [32:0] s, input logic [15:0] n, input logic [24:0] g);
        logic [32:0] p;
        logic [24:0] m;
        exp_t        e;
        if (exp_q.size() != 0) return;
        e = hold;
        exp_q.push_back(e);
        e.busy = 1'b1;
        exp_q.push_back(e);
        p = (s == 33'd0) ? 33'd1 : s;
        m = 25'd0;
        for (int k = 0; k < int'(n); k++) begin
            e.ci   = p;
            e.busy = 1'b1;
            e.done = 1'b0;
            e.pass = 1'b0;
            e.sig  = 25'd0;
            exp_q.push_back(e);
            m = {m[23:0], m[24] ^ m[21]} ^ p[24:0];
            p = {p[31:0], p[32] ^ p[19]};
        end
        e.ci   = p;
        e.busy = 1'b0;
        e.done = 1'b1;
        e.sig  = m;
        e.pass = (m == g);
        exp_q.push_back(e);
        hold      = e;
        hold.done = 1'b0;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = hold;
        chk("cut_in", 64'(cut_in), 64'(e.ci));
        chk("busy", 64'(busy), 64'(e.busy));
        chk("done", 64'(done), 64'(e.done));
        chk("pass", 64'(pass), 64'(e.pass));
        chk("signature", 64'(signature), 64'(e.sig));
        if (done === 1'b1) done_cnt++;
    end

    task automatic run(input logic [32:0] s, input logic [15:0] n, input logic [24:0] g,
                       input int extra, output int lat, output int bcnt);
        int cyc;
        bit got;
        @(posedge clk);
        #1;
        seed    = s;
        num_pat = n;
        golden  = g;
        start   = 1'b1;
        model_start(s, n, g);
        cyc  = 0;
        bcnt = 0;
        lat  = -1;
        got  = 1'b0;
        while (!got && cyc <= int'(n) + 8) begin
            @(negedge clk);
            if (cyc < 16) obs[cyc] = cut_in;
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                got = 1'b1;
                lat = cyc;
            end else begin
                @(posedge clk);
                #1;
                start = (cyc + 1 == extra);
                if (start) model_start(s, n, g);
                cyc++;
            end
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_cut_in"}, 64'(cut_in), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_signature"}, 64'(signature), 64'd0);
    endtask

    initial begin
        int lat;
        int bcnt;
        int dc;
        rst_n   = 1'b1;
        start   = 1'b0;
        seed    = 33'd0;
        num_pat = 16'd0;
        golden  = 25'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // seed 1, one pattern
        run(33'h1, 16'd1, 25'h1, -1, lat, bcnt);
        chk("t1_latency", 64'(lat), 64'd3);
        chk("t1_signature", 64'(signature), 64'h1);
        chk("t1_pass", 64'(pass), 64'd1);

        // back-to-back: seed 1, three patterns
        run(33'h1, 16'd3, 25'h0, -1, lat, bcnt);
        chk("t2_pat0", 64'(obs[2]), 64'h1);
        chk("t2_pat1", 64'(obs[3]), 64'h2);
        chk("t2_pat2", 64'(obs[4]), 64'h4);
        chk("t2_busy_cycles", 64'(bcnt), 64'd4);
        chk("t2_latency", 64'(lat), 64'd5);
        chk("t2_signature", 64'(signature), 64'h4);
        chk("t2_pass", 64'(pass), 64'd0);

        // zero seed substitutes 1
        run(33'h0, 16'd2, 25'h0, -1, lat, bcnt);
        chk("t3_pat0", 64'(obs[2]), 64'h1);
        chk("t3_pat1", 64'(obs[3]), 64'h2);
        chk("t3_signature", 64'(signature), 64'h0);
        chk("t3_pass", 64'(pass), 64'd1);

        // zero patterns
        repeat (2) @(posedge clk);
        run(33'h0_5A5A_5A5A, 16'd0, 25'h0, -1, lat, bcnt);
        chk("t4_latency", 64'(lat), 64'd2);
        chk("t4_signature", 64'(signature), 64'h0);
        chk("t4_pass", 64'(pass), 64'd1);
        chk("t4_cut_in", 64'(cut_in), 64'h0_5A5A_5A5A);

        // longer run with a wide seed, checked by the trace model
        run(33'h1_ABCD_1234, 16'd20, 25'h0, -1, lat, bcnt);
        chk("t5_latency", 64'(lat), 64'd22);

        // start pulsed during RUN is ignored
        repeat (3) @(posedge clk);
        dc = done_cnt;
        run(33'h1, 16'd5, 25'h10, 4, lat, bcnt);
        repeat (4) @(posedge clk);
        chk("t6_done_pulses", 64'(done_cnt - dc), 64'd1);
        chk("t6_latency", 64'(lat), 64'd7);
        chk("t6_signature", 64'(signature), 64'h10);
        chk("t6_pass", 64'(pass), 64'd1);

        // reset in the middle of a 100-pattern run
        @(posedge clk);
        #1;
        seed    = 33'h0_0F0F_0F0F;
        num_pat = 16'd100;
        golden  = 25'h0;
        start   = 1'b1;
        model_start(seed, num_pat, golden);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        chk("t7_busy_before_reset", 64'(busy), 64'd1);
        dc    = done_cnt;
        rst_n = 1'b0;
        exp_q.delete();
        hold = '0;
        #1;
        chk_zero_outputs("t7_async");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (110) @(posedge clk);
        chk("t7_no_done", 64'(done_cnt - dc), 64'd0);
        run(33'h1, 16'd3, 25'h4, -1, lat, bcnt);
        chk("t7_rerun_signature", 64'(signature), 64'h4);
        chk("t7_rerun_pass", 64'(pass), 64'd1);
        chk("t7_rerun_latency", 64'(lat), 64'd5);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
